// File: rtl/microstep_sequencer.sv
// Microstep sequencer: keeps the electrical phase and, through a shared cosine LUT,
// converts a snapshot of it into two coil current magnitudes and polarities.
module microstep_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             ena,
    input  logic             step,
    input  logic             dir,
    input  logic [2:0]       msteps,
    input  logic             home,
    output logic [5:0]       cos_index,
    input  logic [7:0]       cos_value,
    output logic [7:0]       vref_a,
    output logic [7:0]       vref_b,
    output logic             pol_a,
    output logic             pol_b,
    output logic [7:0]       phase,
    output logic             valid,
    output logic [CNT_W-1:0] coalesce_cnt
);

    typedef enum logic [1:0] {IDLE, LUT_A, LUT_B, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [7:0]       snap_q, snap_d;
    logic             pending_q, pending_d;
    logic [7:0]       mag_a_q, mag_b_q;
    logic [7:0]       vref_a_q, vref_b_q;
    logic             pol_a_q, pol_b_q;
    logic             valid_q;
    logic [CNT_W-1:0] coalesce_q;

    logic             change;
    logic [7:0]       stepSize;
    logic [5:0]       idxA;

    assign change   = ena & (step | home);
    assign stepSize = 8'd1 << ((msteps > 3'd6) ? 3'd6 : msteps);

    always_comb begin
        phase_d = phase_q;
        if (change) begin
            if (home)
                phase_d = 8'd0;
            else if (dir)
                phase_d = phase_q + stepSize;
            else
                phase_d = phase_q - stepSize;
        end
    end

    // A refresh restarts from the freshest phase; changes arriving mid-refresh are remembered in pending.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        case (state_q)
            IDLE:    if (change || pending_q) state_d = LUT_A;
            LUT_A:   state_d = LUT_B;
            LUT_B:   state_d = COMMIT;
            COMMIT:  state_d = (change || pending_q) ? LUT_A : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == LUT_A) begin
            snap_d    = phase_d;
            pending_d = 1'b0;
        end else if (change && state_q != IDLE) begin
            pending_d = 1'b1;
        end
    end

    // Odd quadrants mirror the table; the other coil always reads the mirrored address.
    assign idxA = snap_q[6] ? ~snap_q[5:0] : snap_q[5:0];

    always_comb begin
        cos_index = 6'd0;
        if (state_q == LUT_A)
            cos_index = idxA;
        else if (state_q == LUT_B)
            cos_index = ~idxA;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            phase_q    <= 8'd0;
            snap_q     <= 8'd0;
            pending_q  <= 1'b1;
            mag_a_q    <= 8'd0;
            mag_b_q    <= 8'd0;
            vref_a_q   <= 8'd0;
            vref_b_q   <= 8'd0;
            pol_a_q    <= 1'b0;
            pol_b_q    <= 1'b0;
            valid_q    <= 1'b0;
            coalesce_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            valid_q   <= (state_q == COMMIT);
            if (state_q == LUT_A)
                mag_a_q <= cos_value;
            if (state_q == LUT_B)
                mag_b_q <= cos_value;
            if (state_q == COMMIT) begin
                vref_a_q <= mag_a_q;
                vref_b_q <= mag_b_q;
                pol_a_q  <= snap_q[7] ^ snap_q[6];
                pol_b_q  <= snap_q[7];
            end
            if (change && pending_q && coalesce_q != '1)
                coalesce_q <= coalesce_q + CNT_W'(1);
        end
    end

    assign phase        = phase_q;
    assign vref_a       = vref_a_q;
    assign vref_b       = vref_b_q;
    assign pol_a        = pol_a_q;
    assign pol_b        = pol_b_q;
    assign valid        = valid_q;
    assign coalesce_cnt = coalesce_q;

endmodule
